// File: rtl/float_byte_assembler.sv
// Packs four big-endian bytes into one IEEE-754 single-precision word, with valid/ready handshakes on both sides.
// Optional partial-word timeout is enabled by defining FLOAT_ASM_TIMEOUT_EN.
module float_byte_assembler #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] num,
  output logic        num_valid,
  input  logic        num_ready,
  output logic [1:0]  byte_cnt,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t      state_r, state_nxt;
  logic [1:0]  byte_cnt_r, byte_cnt_nxt;
  logic [23:0] asm_r, asm_nxt;
  logic [31:0] num_r, num_nxt;
  logic        num_valid_r, num_valid_nxt;
  logic        byte_xfer_s, word_xfer_s, tmo_hit_s;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..255");
  end

  // Places byte b at slot idx of the 24-bit assembly register (slot 0 = most significant).
  function automatic logic [23:0] load_byte(input logic [23:0] a, input logic [1:0] idx,
                                            input logic [7:0] b);
    logic [23:0] r;
    case (idx)
      2'd0:    r = {b, a[15:0]};
      2'd1:    r = {a[23:16], b, a[7:0]};
      2'd2:    r = {a[23:8], b};
      default: r = a;
    endcase
    return r;
  endfunction

  assign in_ready    = !num_valid_r || num_ready;
  assign byte_xfer_s = in_valid && in_ready;
  assign word_xfer_s = num_valid_r && num_ready;

`ifdef FLOAT_ASM_TIMEOUT_EN
  localparam logic [7:0] IDLE_TERM = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] idle_cnt_r, idle_cnt_nxt;
  logic       timeout_r;

  // Idle counter: counts RECV cycles without a byte; a coinciding byte beats the terminal count.
  always_comb begin
    idle_cnt_nxt = 8'd0;
    tmo_hit_s    = 1'b0;
    if (state_r == RECV && !byte_xfer_s) begin
      if (idle_cnt_r == IDLE_TERM) begin
        tmo_hit_s    = 1'b1;
        idle_cnt_nxt = 8'd0;
      end else begin
        idle_cnt_nxt = idle_cnt_r + 8'd1;
      end
    end else begin
      idle_cnt_nxt = 8'd0;
    end
  end

  // Idle counter and timeout pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_r <= 8'd0;
      timeout_r  <= 1'b0;
    end else begin
      idle_cnt_r <= idle_cnt_nxt;
      timeout_r  <= tmo_hit_s;
    end
  end

  assign timeout = timeout_r;
`else
  assign tmo_hit_s = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Next-state and datapath update for the IDLE/RECV/FULL assembler.
  always_comb begin
    state_nxt    = state_r;
    byte_cnt_nxt = byte_cnt_r;
    asm_nxt      = asm_r;
    num_nxt      = num_r;
    case (state_r)
      IDLE: begin
        if (byte_xfer_s) begin
          state_nxt    = RECV;
          byte_cnt_nxt = 2'd1;
          asm_nxt      = load_byte(asm_r, 2'd0, in_byte);
        end else begin
          state_nxt = IDLE;
        end
      end
      RECV: begin
        if (byte_xfer_s) begin
          if (byte_cnt_r == 2'd3) begin
            state_nxt    = FULL;
            byte_cnt_nxt = 2'd0;
            num_nxt      = {asm_r, in_byte};
          end else begin
            byte_cnt_nxt = byte_cnt_r + 2'd1;
            asm_nxt      = load_byte(asm_r, byte_cnt_r, in_byte);
          end
        end else if (tmo_hit_s) begin
          state_nxt    = IDLE;
          byte_cnt_nxt = 2'd0;
          asm_nxt      = 24'd0;
        end else begin
          state_nxt = RECV;
        end
      end
      FULL: begin
        // A byte can only be taken here together with the word leaving, so it starts the next word.
        if (word_xfer_s) begin
          if (byte_xfer_s) begin
            state_nxt    = RECV;
            byte_cnt_nxt = 2'd1;
            asm_nxt      = load_byte(asm_r, 2'd0, in_byte);
          end else begin
            state_nxt    = IDLE;
            byte_cnt_nxt = 2'd0;
          end
        end else begin
          state_nxt = FULL;
        end
      end
      default: begin
        state_nxt    = IDLE;
        byte_cnt_nxt = 2'd0;
      end
    endcase
    num_valid_nxt = (state_nxt == FULL);
  end

  // State, assembly and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      byte_cnt_r  <= 2'd0;
      asm_r       <= 24'd0;
      num_r       <= 32'h0000_0000;
      num_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      byte_cnt_r  <= byte_cnt_nxt;
      asm_r       <= asm_nxt;
      num_r       <= num_nxt;
      num_valid_r <= num_valid_nxt;
    end
  end

  assign num       = num_r;
  assign num_valid = num_valid_r;
  assign byte_cnt  = byte_cnt_r;

endmodule

// File: tb/tb_float_byte_assembler.sv
// Scoreboard-based bench for float_byte_assembler; timeout expectations follow FLOAT_ASM_TIMEOUT_EN.
module tb_float_byte_assembler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] num;
  logic        num_valid;
  logic        num_ready = 1'b0;
  logic [1:0]  byte_cnt;
  logic        timeout;

  int tests_run = 0;
  int fails = 0;
  int words_seen = 0;
  int cyc = 0;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;

  float_byte_assembler #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .num(num), .num_valid(num_valid), .num_ready(num_ready), .byte_cnt(byte_cnt),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Word monitor: a transfer happens at the next rising edge; compare against the scoreboard.
  always @(negedge clk) begin
    if (!reset && num_valid && num_ready) begin
      tests_run = tests_run + 1;
      words_seen = words_seen + 1;
      if (sb.size() == 0) begin
        fails = fails + 1;
        $display("FAIL word_unexpected got=%h expected=none", num);
      end else begin
        mon_exp = sb.pop_front();
        if (num !== mon_exp) begin
          fails = fails + 1;
          $display("FAIL word_value got=%h expected=%h", num, mon_exp);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_byte = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests_run++;
      fails++;
      $display("FAIL send_wait got=in_ready_low expected=in_ready_high");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit push);
    logic [1:0] exp_cnt;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      exp_cnt = 2'(i + 1);
      tests_run++;
      if (byte_cnt !== exp_cnt) begin
        fails++;
        $display("FAIL byte_cnt_step got=%0d expected=%0d", byte_cnt, exp_cnt);
      end
    end
    if (push) sb.push_back(w);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run += 5;
    if (byte_cnt !== 2'd0) begin fails++; $display("FAIL rst_byte_cnt got=%0d expected=0", byte_cnt); end
    if (num !== 32'h0) begin fails++; $display("FAIL rst_num got=%h expected=00000000", num); end
    if (num_valid !== 1'b0) begin fails++; $display("FAIL rst_num_valid got=%b expected=0", num_valid); end
    if (timeout !== 1'b0) begin fails++; $display("FAIL rst_timeout got=%b expected=0", timeout); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got=%b expected=1", in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_inf();
    num_ready = 1'b1;
    send_word(32'h7F80_0000, 1'b1);
    tests_run += 2;
    if (num_valid !== 1'b1) begin fails++; $display("FAIL inf_valid got=%b expected=1", num_valid); end
    if (num !== 32'h7F80_0000) begin fails++; $display("FAIL inf_num got=%h expected=7f800000", num); end
    @(posedge clk);
    #1;
    tests_run++;
    if (num_valid !== 1'b0) begin fails++; $display("FAIL inf_valid_drop got=%b expected=0", num_valid); end
  endtask

  task automatic test_backpressure();
    num_ready = 1'b0;
    send_word(32'h3F80_0000, 1'b1);
    in_byte = 8'h00;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run += 3;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got=%b expected=0", in_ready); end
      if (num !== 32'h3F80_0000) begin fails++; $display("FAIL stall_num got=%h expected=3f800000", num); end
      if (byte_cnt !== 2'd0) begin fails++; $display("FAIL stall_byte_cnt got=%0d expected=0", byte_cnt); end
      @(posedge clk);
      #1;
    end
    num_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests_run += 2;
    if (byte_cnt !== 2'd1) begin fails++; $display("FAIL release_byte_cnt got=%0d expected=1", byte_cnt); end
    if (num_valid !== 1'b0) begin fails++; $display("FAIL release_valid got=%b expected=0", num_valid); end
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    sb.push_back(32'h0011_2233);
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int c0;
    int w0;
    num_ready = 1'b1;
    c0 = cyc;
    w0 = words_seen;
    send_word(32'h0000_0001, 1'b1);
    send_word(32'hFF80_0001, 1'b1);
    tests_run++;
    if (cyc - c0 !== 8) begin fails++; $display("FAIL b2b_cycles got=%0d expected=8", cyc - c0); end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (words_seen - w0 !== 2) begin fails++; $display("FAIL b2b_words got=%0d expected=2", words_seen - w0); end
  endtask

  task automatic test_async_reset();
    int w0;
    num_ready = 1'b1;
    send_byte(8'h80);
    send_byte(8'h00);
    #2;
    reset = 1'b1;
    #1;
    tests_run += 2;
    if (byte_cnt !== 2'd0) begin fails++; $display("FAIL arst_byte_cnt got=%0d expected=0", byte_cnt); end
    if (num_valid !== 1'b0) begin fails++; $display("FAIL arst_valid got=%b expected=0", num_valid); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_word(32'h4049_0FDB, 1'b1);
    @(posedge clk);
    #1;
    num_ready = 1'b0;
    send_word(32'hDEAD_BEEF, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (num_valid !== 1'b0) begin fails++; $display("FAIL arst_full_valid got=%b expected=0", num_valid); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    w0 = words_seen;
    num_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (words_seen !== w0) begin fails++; $display("FAIL arst_discard got=%0d expected=%0d", words_seen, w0); end
  endtask

  task automatic idle_and_expect_timeout();
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      tests_run += 2;
      if (timeout !== (k == 4)) begin fails++; $display("FAIL tmo_pulse got=%b expected=%b k=%0d", timeout, (k == 4), k); end
      if (byte_cnt !== ((k == 4) ? 2'd0 : 2'd1) && k != 4) begin fails++; $display("FAIL tmo_cnt_hold got=%0d expected=1 k=%0d", byte_cnt, k); end
      if (k == 4 && byte_cnt !== 2'd0) begin fails++; $display("FAIL tmo_cnt_clear got=%0d expected=0", byte_cnt); end
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (timeout !== 1'b0) begin fails++; $display("FAIL tmo_once got=%b expected=0", timeout); end
  endtask

  task automatic test_timeout();
    num_ready = 1'b1;
`ifdef FLOAT_ASM_TIMEOUT_EN
    send_byte(8'h12);
    idle_and_expect_timeout();
    send_word(32'h0000_0000, 1'b1);
    @(posedge clk);
    #1;
    send_byte(8'h12);
    repeat (3) @(posedge clk);
    #1;
    send_byte(8'h34);
    tests_run += 2;
    if (timeout !== 1'b0) begin fails++; $display("FAIL tmo_coincide got=%b expected=0", timeout); end
    if (byte_cnt !== 2'd2) begin fails++; $display("FAIL tmo_coincide_cnt got=%0d expected=2", byte_cnt); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (timeout !== (k == 4)) begin fails++; $display("FAIL tmo_restart got=%b expected=%b k=%0d", timeout, (k == 4), k); end
    end
    send_word(32'h0000_0000, 1'b1);
`else
    send_byte(8'h12);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      tests_run += 2;
      if (timeout !== 1'b0) begin fails++; $display("FAIL notmo_pulse got=%b expected=0 k=%0d", timeout, k); end
      if (byte_cnt !== 2'd1) begin fails++; $display("FAIL notmo_cnt got=%0d expected=1 k=%0d", byte_cnt, k); end
    end
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    sb.push_back(32'h1200_0000);
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_inf();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_timeout();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (sb.size() !== 0) begin fails++; $display("FAIL sb_drain got=%0d expected=0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
